// File: rtl/ipdc_pkg.sv
// Shared types for the image-display window engine: opcodes, FSM states,
// and a width helper that never returns zero.
package ipdc_pkg;

  typedef enum logic [2:0] {
    OP_LOAD    = 3'b000,
    OP_RIGHT   = 3'b001,
    OP_DOWN    = 3'b010,
    OP_DEFAULT = 3'b011,
    OP_ZOOM    = 3'b100,
    OP_LEFT    = 3'b101,
    OP_UP      = 3'b110,
    OP_NOP     = 3'b111
  } ipdc_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_UPDATE,
    S_NOP,
    S_DISP
  } ipdc_state_e;

  function automatic int unsigned ipdc_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ipdc_img_buf.sv
// Frame storage: one raster-indexed write port and one combinational
// (row, col) read port.
module ipdc_img_buf
  import ipdc_pkg::*;
#(
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned IMG_DIM = 8
) (
  input  logic                                     i_clk,
  input  logic                                     i_we,
  input  logic [ipdc_width(IMG_DIM*IMG_DIM)-1:0]   i_waddr,
  input  logic [DATA_W-1:0]                        i_wdata,
  input  logic [ipdc_width(IMG_DIM)-1:0]           i_rd_row,
  input  logic [ipdc_width(IMG_DIM)-1:0]           i_rd_col,
  output logic [DATA_W-1:0]                        o_rd_data
);

  localparam int unsigned PIX_W = ipdc_width(IMG_DIM*IMG_DIM);

  logic [DATA_W-1:0] mem [IMG_DIM*IMG_DIM];
  logic [PIX_W-1:0]  rd_idx;

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign rd_idx    = PIX_W'(int'(i_rd_row) * IMG_DIM + int'(i_rd_col));
  assign o_rd_data = mem[rd_idx];

endmodule

// File: rtl/ipdc_window_engine.sv
// Image-display controller: frame load, origin/stride update with saturating
// shifts, and a backpressured raster stream of the display window.
module ipdc_window_engine
  import ipdc_pkg::*;
#(
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned IMG_DIM = 8,
  parameter int unsigned WIN_DIM = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_op_valid,
  input  logic [2:0]        i_op_mode,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  input  logic              i_out_ready,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_data
);

  localparam int unsigned COORD_W = ipdc_width(IMG_DIM);
  localparam int unsigned PIX_W   = ipdc_width(IMG_DIM*IMG_DIM);
  localparam int unsigned CNT_W   = ipdc_width(WIN_DIM*WIN_DIM+1);
  localparam int unsigned WIN_W   = ipdc_width(WIN_DIM);

  localparam logic [COORD_W-1:0] MAX_S1   = COORD_W'(IMG_DIM - WIN_DIM);
  localparam logic [COORD_W-1:0] MAX_S2   = COORD_W'(IMG_DIM - 2*WIN_DIM + 1);
  localparam logic [COORD_W-1:0] ZOOM_ORG = COORD_W'((IMG_DIM - WIN_DIM) / 2);
  localparam logic [PIX_W-1:0]   LAST_PIX = PIX_W'(IMG_DIM*IMG_DIM - 1);
  localparam logic [CNT_W-1:0]   LAST_WIN = CNT_W'(WIN_DIM*WIN_DIM - 1);
  localparam logic [WIN_W-1:0]   WIN_END  = WIN_W'(WIN_DIM - 1);

  ipdc_state_e          state_q, state_nxt;
  ipdc_op_e             op_q;
  logic [COORD_W-1:0]   row_q, col_q;
  logic                 stride_two_q;
  logic [PIX_W-1:0]     ld_idx_q;
  logic [CNT_W-1:0]     win_cnt_q;
  logic [WIN_W-1:0]     win_r_q, win_c_q, nxt_r, nxt_c;

  logic [COORD_W-1:0]   upd_row, upd_col, sh_max;
  logic                 upd_two;
  logic [COORD_W-1:0]   base_r, base_c, rd_row, rd_col;
  logic [WIN_W-1:0]     off_r, off_c;
  logic                 rd_two;
  logic [DATA_W-1:0]    rd_data;

  logic op_accept, ld_we, handshake, ld_last, win_last;

  assign op_accept = (state_q == S_IDLE) && i_op_valid;
  assign ld_we     = (state_q == S_LOAD) && i_in_valid && !i_rst;
  assign ld_last   = ld_idx_q == LAST_PIX;
  assign handshake = (state_q == S_DISP) && o_out_valid && i_out_ready;
  assign win_last  = win_cnt_q == LAST_WIN;

  ipdc_img_buf #(
    .DATA_W  (DATA_W),
    .IMG_DIM (IMG_DIM)
  ) u_img_buf (
    .i_clk     (i_clk),
    .i_we      (ld_we),
    .i_waddr   (ld_idx_q),
    .i_wdata   (i_in_data),
    .i_rd_row  (rd_row),
    .i_rd_col  (rd_col),
    .o_rd_data (rd_data)
  );

  // Origin/stride the pending op will produce; shifts saturate at the
  // legal range for the current stride.
  always_comb begin
    upd_row = row_q;
    upd_col = col_q;
    upd_two = stride_two_q;
    sh_max  = stride_two_q ? MAX_S2 : MAX_S1;
    case (op_q)
      OP_RIGHT:   if (col_q < sh_max) upd_col = col_q + COORD_W'(1);
      OP_LEFT:    if (col_q != '0)    upd_col = col_q - COORD_W'(1);
      OP_DOWN:    if (row_q < sh_max) upd_row = row_q + COORD_W'(1);
      OP_UP:      if (row_q != '0)    upd_row = row_q - COORD_W'(1);
      OP_DEFAULT: begin
        upd_row = '0;
        upd_col = '0;
        upd_two = 1'b1;
      end
      OP_ZOOM: begin
        upd_row = ZOOM_ORG;
        upd_col = ZOOM_ORG;
        upd_two = 1'b0;
      end
      default: ;
    endcase
  end

  // Read address looks one pixel ahead so the output register is loaded
  // on the same edge as the handshake (or the UPDATE edge for pixel 0).
  always_comb begin
    nxt_c = (win_c_q == WIN_END) ? '0 : win_c_q + WIN_W'(1);
    nxt_r = (win_c_q == WIN_END) ? win_r_q + WIN_W'(1) : win_r_q;
    if (state_q == S_UPDATE) begin
      base_r = upd_row;
      base_c = upd_col;
      rd_two = upd_two;
      off_r  = '0;
      off_c  = '0;
    end else begin
      base_r = row_q;
      base_c = col_q;
      rd_two = stride_two_q;
      off_r  = nxt_r;
      off_c  = nxt_c;
    end
    rd_row = base_r + (rd_two ? COORD_W'({off_r, 1'b0}) : COORD_W'(off_r));
    rd_col = base_c + (rd_two ? COORD_W'({off_c, 1'b0}) : COORD_W'(off_c));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_op_valid) begin
          case (ipdc_op_e'(i_op_mode))
            OP_LOAD: state_nxt = S_LOAD;
            OP_NOP:  state_nxt = S_NOP;
            default: state_nxt = S_UPDATE;
          endcase
        end
      end
      S_LOAD:   if (i_in_valid && ld_last) state_nxt = S_IDLE;
      S_UPDATE: state_nxt = S_DISP;
      S_NOP:    state_nxt = S_IDLE;
      S_DISP:   if (handshake && win_last) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_in_ready   <= 1'b1;
      o_out_valid  <= 1'b0;
      o_out_data   <= '0;
      op_q         <= OP_NOP;
      row_q        <= '0;
      col_q        <= '0;
      stride_two_q <= 1'b1;
      ld_idx_q     <= '0;
      win_cnt_q    <= '0;
      win_r_q      <= '0;
      win_c_q      <= '0;
    end else begin
      o_in_ready <= (state_nxt == S_IDLE);
      if (op_accept) op_q <= ipdc_op_e'(i_op_mode);
      if (ld_we) ld_idx_q <= ld_last ? '0 : ld_idx_q + PIX_W'(1);
      if (state_q == S_UPDATE) begin
        row_q        <= upd_row;
        col_q        <= upd_col;
        stride_two_q <= upd_two;
        win_cnt_q    <= '0;
        win_r_q      <= '0;
        win_c_q      <= '0;
        o_out_valid  <= 1'b1;
        o_out_data   <= rd_data;
      end
      if (handshake) begin
        if (win_last) begin
          o_out_valid <= 1'b0;
        end else begin
          win_cnt_q  <= win_cnt_q + CNT_W'(1);
          win_r_q    <= nxt_r;
          win_c_q    <= nxt_c;
          o_out_data <= rd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_ipdc_window_engine.sv
// Scoreboard bench for ipdc_window_engine at 8x8 frame, 4x4 window, 24-bit pixels.
module tb_ipdc_window_engine;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_op_valid = 1'b0;
  logic [2:0]  i_op_mode = '0;
  logic        i_in_valid = 1'b0;
  logic [23:0] i_in_data = '0;
  logic        o_in_ready;
  logic        i_out_ready = 1'b0;
  logic        o_out_valid;
  logic [23:0] o_out_data;

  ipdc_window_engine #(
    .DATA_W  (24),
    .IMG_DIM (8),
    .WIN_DIM (4)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_op_valid  (i_op_valid),
    .i_op_mode   (i_op_mode),
    .i_in_valid  (i_in_valid),
    .i_in_data   (i_in_data),
    .o_in_ready  (o_in_ready),
    .i_out_ready (i_out_ready),
    .o_out_valid (o_out_valid),
    .o_out_data  (o_out_data)
  );

  always #5 i_clk = ~i_clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          hs_cnt = 0;
  logic [23:0] exp_q[$];
  logic [23:0] frame[64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Monitor: pops on every handshake and checks data holds while stalled.
  initial begin : monitor
    logic        stalled;
    logic [23:0] held;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          n_cmp++;
          if (o_out_valid !== 1'b1 || o_out_data !== held) begin
            n_err++;
            $display("FAIL stall_hold: valid=%0b data=%0d, expected valid=1 data=%0d",
                     o_out_valid, o_out_data, held);
          end
        end
        if (o_out_valid && i_out_ready) begin
          hs_cnt++;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_pixel: got %0d, expected no output", o_out_data);
          end else begin
            logic [23:0] e;
            e = exp_q.pop_front();
            if (o_out_data !== e) begin
              n_err++;
              $display("FAIL pixel: got %0d, expected %0d", o_out_data, e);
            end
          end
        end
        stalled = o_out_valid && !i_out_ready;
        held    = o_out_data;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [2:0] op);
    int w;
    w = 0;
    while (!o_in_ready && w < 100) begin
      tick();
      w++;
    end
    chk("ready_before_op", o_in_ready, 1);
    i_op_valid = 1'b1;
    i_op_mode  = op;
    tick();
    i_op_valid = 1'b0;
    chk("busy_after_accept", o_in_ready, 0);
  endtask

  task automatic push_win(input int r, input int c, input int s);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        exp_q.push_back(frame[(r + s*i)*8 + c + s*j]);
  endtask

  task automatic load(input int base, input bit gaps);
    issue(3'b000);
    for (int k = 0; k < 64; k++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        for (int n = 0; n < g; n++) begin
          i_in_valid = 1'b0;
          i_in_data  = 24'($urandom);
          i_op_valid = 1'($urandom_range(0, 1));
          i_op_mode  = 3'b011;
          tick();
        end
        i_op_valid = 1'b0;
      end
      i_in_valid = 1'b1;
      i_in_data  = 24'(base + k);
      frame[k]   = 24'(base + k);
      tick();
      i_in_valid = 1'b0;
      if (k == 31) chk("busy_mid_load", o_in_ready, 0);
    end
    chk("ready_after_load", o_in_ready, 1);
  endtask

  // Runs one display op; r/c/s is the hand-derived origin after the op.
  task automatic disp(input logic [2:0] op, input int r, input int c, input int s, input bit bp);
    int hs0;
    int cyc;
    push_win(r, c, s);
    hs0 = hs_cnt;
    issue(op);
    chk("update_cycle_no_valid", o_out_valid, 0);
    for (cyc = 0; cyc < 200; cyc++) begin
      i_out_ready = bp ? ((cyc % 2) == 0) : 1'b1;
      tick();
      if (cyc == 0) chk("first_valid_latency", o_out_valid, 1);
      if (o_in_ready) break;
    end
    i_out_ready = 1'b0;
    chk("disp_done", o_in_ready, 1);
    chk("valid_low_after_disp", o_out_valid, 0);
    chk("handshake_count", 32'(hs_cnt - hs0), 16);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
  endtask

  initial begin : stim
    repeat (3) tick();
    chk("rst_in_ready", o_in_ready, 1);
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_out_data", o_out_data, 0);
    i_rst = 1'b0;
    tick();

    load(0, 1'b0);
    disp(3'b011, 0, 0, 2, 1'b0);
    disp(3'b001, 0, 1, 2, 1'b0);
    disp(3'b001, 0, 1, 2, 1'b0);
    disp(3'b101, 0, 0, 2, 1'b0);
    disp(3'b101, 0, 0, 2, 1'b0);
    disp(3'b110, 0, 0, 2, 1'b0);
    disp(3'b100, 2, 2, 1, 1'b0);
    disp(3'b001, 2, 3, 1, 1'b0);
    disp(3'b001, 2, 4, 1, 1'b0);
    disp(3'b001, 2, 4, 1, 1'b0);
    disp(3'b011, 0, 0, 2, 1'b1);

    load(1000, 1'b1);
    i_in_valid = 1'b1;
    i_in_data  = 24'hFFFFFF;
    repeat (3) tick();
    i_in_valid = 1'b0;
    disp(3'b011, 0, 0, 2, 1'b0);

    push_win(0, 0, 2);
    issue(3'b011);
    i_out_ready = 1'b1;
    repeat (5) tick();
    i_out_ready = 1'b0;
    i_rst = 1'b1;
    tick();
    chk("midrst_out_valid", o_out_valid, 0);
    chk("midrst_in_ready", o_in_ready, 1);
    i_rst = 1'b0;
    exp_q.delete();
    tick();

    disp(3'b010, 1, 0, 2, 1'b0);

    issue(3'b111);
    chk("nop_no_valid", o_out_valid, 0);
    tick();
    chk("nop_ready_back", o_in_ready, 1);
    chk("nop_no_valid_after", o_out_valid, 0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
